// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer: one 4-bit adder reused NIB times, LSB nibble first.
// Optional SIGNED_OVF_EN adds an ovf output flagging two's-complement overflow.
module four_bit_full_adder (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);
   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};
endmodule

// state  | meaning
// S_IDLE | ready for a new operand set
// S_RUN  | one nibble processed per cycle, carry held in carry_q
// S_DONE | result/cout held until out_ready
module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
`ifdef SIGNED_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);
   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
   logic             sub_q, sub_d, carry_q, carry_d, cout_q, cout_d;
`ifdef SIGNED_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic [IW+1:0]    base;
   logic [3:0]       a_nib, b_eff, sum_nib;
   logic             add_cout;
   logic             last_nib;

   assign base     = {idx_q, 2'b00};
   assign a_nib    = a_q[base +: 4];
   assign b_eff    = sub_q ? ~b_q[base +: 4] : b_q[base +: 4];
   assign last_nib = (idx_q == IW'(NIB - 1));

   four_bit_full_adder u_adder (
      .a_i    (a_nib),
      .b_i    (b_eff),
      .cin_i  (carry_q),
      .sum_o  (sum_nib),
      .cout_o (add_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         carry_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
`ifdef SIGNED_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sub_q    <= sub_d;
         carry_q  <= carry_d;
         result_q <= result_d;
         cout_q   <= cout_d;
`ifdef SIGNED_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      sub_d    = sub_q;
      carry_d  = carry_q;
      result_d = result_q;
      cout_d   = cout_q;
`ifdef SIGNED_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               sub_d   = sub;
               carry_d = sub;
               idx_d   = '0;
`ifdef SIGNED_OVF_EN
               ovf_d   = 1'b0;
`endif
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            result_d[base +: 4] = sum_nib;
            carry_d             = add_cout;
            if (last_nib) begin
               cout_d  = add_cout;
               idx_d   = '0;
`ifdef SIGNED_OVF_EN
               // carry into MSB xor carry out of MSB
               ovf_d   = a_nib[3] ^ b_eff[3] ^ sum_nib[3] ^ add_cout;
`endif
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign cout      = cout_q;
`ifdef SIGNED_OVF_EN
   assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl (WIDTH=16): vector table, random ops, and
// hand sequences for latency, backpressure and mid-operation reset.
module tb_nibble_serial_adder_ctrl;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0, b = '0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic         cout;
`ifdef SIGNED_OVF_EN
   logic         ovf;
`endif

   always #5 clk = ~clk;

   nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
`ifdef SIGNED_OVF_EN
      .ovf       (ovf),
`endif
      .cout      (cout)
   );

   typedef struct {
      logic [W-1:0] res;
      logic         c;
      logic         v;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic [W-1:0] res;
      logic         c;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s);
      exp_t         e;
      logic [W-1:0] be;
      logic [W:0]   t;
      be    = s ? ~bb : bb;
      t     = {1'b0, aa} + {1'b0, be} + (W+1)'(s);
      e.res = t[W-1:0];
      e.c   = t[W];
      e.v   = (aa[W-1] == be[W-1]) && (t[W-1] != aa[W-1]);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Scoreboard: compare on every output handshake
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: result 0x%0h with empty scoreboard", result);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("result", 32'(result), 32'(e.res));
            check("cout", 32'(cout), 32'(e.c));
`ifdef SIGNED_OVF_EN
            check("ovf", 32'(ovf), 32'(e.v));
`endif
         end
      end
   end

   task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s,
                       input bit push, input exp_t e);
      bit ok;
      ok = 0;
      @(posedge clk); #1;
      a = aa; b = bb; sub = s; in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready never 1, required 1");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = ~aa; b = ~bb; sub = ~s;
      if (push) sb_q.push_back(e);
   endtask

   task automatic wait_out();
      bit ok;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL out_timeout: out_valid never 1, required 1");
      end
      @(posedge clk); #1;
   endtask

   task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic s,
                         input logic [W-1:0] res, input logic c);
      exp_t e;
      e     = model(aa, bb, s);
      e.res = res;
      e.c   = c;
      send(aa, bb, s, 1'b1, e);
      wait_out();
   endtask

   vec_t vecs[10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra, rb, hold_r;
      logic         rs, hold_c;
      exp_t         e;

      vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0};
      vecs[3] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1};
      vecs[4] = '{16'hBEEF, 16'h0000, 1'b1, 16'hBEEF, 1'b1};
      vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
      vecs[6] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1};
      vecs[7] = '{16'h0003, 16'hFFFF, 1'b0, 16'h0002, 1'b1};
      vecs[8] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
`ifdef SIGNED_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif

      // Latency: out_valid appears in cycle 5 after the accept edge
      e = model(16'h1234, 16'h0FFF, 1'b0);
      send(16'h1234, 16'h0FFF, 1'b0, 1'b1, e);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("lat_in_ready_c%0d", k), 32'(in_ready), 32'd0);
         check($sformatf("lat_out_valid_c%0d", k), 32'(out_valid), (k == 5) ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1;
      @(negedge clk);
      check("lat_back_idle", 32'(in_ready), 32'd1);

      for (int i = 0; i < 10; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].res, vecs[i].c);

      for (int i = 0; i < 8; i++) begin
         ra = W'($urandom_range(0, 65535));
         rb = W'($urandom_range(0, 65535));
         rs = 1'($urandom_range(0, 1));
         e  = model(ra, rb, rs);
         run_op(ra, rb, rs, e.res, e.c);
      end

      // Backpressure: outputs stable, new operands ignored while in DONE
      out_ready = 1'b0;
      e = model(16'h4321, 16'h1111, 1'b1);
      send(16'h4321, 16'h1111, 1'b1, 1'b1, e);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      hold_r = result;
      hold_c = cout;
      check("bp_result_value", 32'(hold_r), 32'h3210);
      @(posedge clk); #1;
      a = 16'h1111; b = 16'h2222; sub = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_result_stable", 32'(result), 32'(hold_r));
         check("bp_cout_stable", 32'(cout), 32'(hold_c));
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_idle_in_ready", 32'(in_ready), 32'd1);
      check("bp_idle_out_valid", 32'(out_valid), 32'd0);

      // Reset in RUN cycle 2 discards the operation
      e = model(16'hAAAA, 16'h5555, 1'b0);
      send(16'hAAAA, 16'h5555, 1'b0, 1'b0, e);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("mrst_in_ready", 32'(in_ready), 32'd1);
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_result", 32'(result), 32'd0);
      check("mrst_cout", 32'(cout), 32'd0);
      run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
